// File: rtl/mcpu.sv
// mcpu: multi-cycle MIPS-subset core with one shared instruction/data memory port.
module mcpu (
   input  logic        clk,
   input  logic        reset,
   input  logic        INT,
   input  logic        MIO_ready,
   input  logic [31:0] Data_in,
   output logic        mem_w,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic [31:0] Data_out,
   output logic [31:0] Addr_out,
   output logic        CPU_MIO,
   output logic [4:0]  state
);

   typedef enum logic [4:0] {
      S_IF       = 5'd0,
      S_ID       = 5'd1,
      S_MEM_ADDR = 5'd2,
      S_MEM_RD   = 5'd3,
      S_WB_LW    = 5'd4,
      S_MEM_WR   = 5'd5,
      S_EX_R     = 5'd6,
      S_WB_R     = 5'd7,
      S_EX_BR    = 5'd8,
      S_EX_J     = 5'd9,
      S_EX_I     = 5'd10,
      S_WB_I     = 5'd11,
      S_EX_JAL   = 5'd12,
      S_EX_JR    = 5'd13
   } state_t;

   state_t      cur, nxt;
   logic [31:0] pc, ir, mdr, a, b, alu_out;
   logic [31:0] rf [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm_se, imm_ze, jtarget, rs_val, rt_val;
   logic [31:0] r_result, i_result;
   logic        br_taken;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   // interrupt input is reserved; tie it off so it is visibly consumed
   logic unused_int;
   assign unused_int = INT;

   assign op      = ir[31:26];
   assign rs      = ir[25:21];
   assign rt      = ir[20:16];
   assign rd      = ir[15:11];
   assign shamt   = ir[10:6];
   assign funct   = ir[5:0];
   assign imm_se  = {{16{ir[15]}}, ir[15:0]};
   assign imm_ze  = {16'h0000, ir[15:0]};
   assign jtarget = {pc[31:28], ir[25:0], 2'b00};
   assign rs_val  = (rs == 5'd0) ? '0 : rf[rs];
   assign rt_val  = (rt == 5'd0) ? '0 : rf[rt];

   assign PC_out   = pc;
   assign inst_out = ir;
   assign Data_out = b;
   assign state    = cur;

   // R-type ALU: register/register ops and shamt shifts of B
   always_comb begin
      r_result = '0;
      case (funct)
         6'h20:   r_result = a + b;
         6'h22:   r_result = a - b;
         6'h24:   r_result = a & b;
         6'h25:   r_result = a | b;
         6'h26:   r_result = a ^ b;
         6'h27:   r_result = ~(a | b);
         6'h2A:   r_result = {31'b0, $signed(a) < $signed(b)};
         6'h00:   r_result = b << shamt;
         6'h02:   r_result = b >> shamt;
         default: r_result = '0;
      endcase
   end

   // I-type ALU: register/immediate ops with per-opcode extension
   always_comb begin
      i_result = '0;
      case (op)
         6'h08:   i_result = a + imm_se;
         6'h0C:   i_result = a & imm_ze;
         6'h0D:   i_result = a | imm_ze;
         6'h0E:   i_result = a ^ imm_ze;
         6'h0A:   i_result = {31'b0, $signed(a) < $signed(imm_se)};
         6'h0F:   i_result = {ir[15:0], 16'h0000};
         default: i_result = '0;
      endcase
   end

   assign br_taken = ((op == 6'h04) && (a == b)) || ((op == 6'h05) && (a != b));

   // state register
   always_ff @(posedge clk) begin
      if (!reset) cur <= S_IF;
      else        cur <= nxt;
   end

   // next-state logic; ID decodes, unsupported encodings fall back to IF
   always_comb begin
      nxt = cur;
      case (cur)
         S_IF:       nxt = MIO_ready ? S_ID : S_IF;
         S_ID: begin
            case (op)
               6'h00: begin
                  case (funct)
                     6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                     6'h27, 6'h2A, 6'h00, 6'h02:       nxt = S_EX_R;
                     6'h08:                            nxt = S_EX_JR;
                     default:                          nxt = S_IF;
                  endcase
               end
               6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F: nxt = S_EX_I;
               6'h23, 6'h2B:                             nxt = S_MEM_ADDR;
               6'h04, 6'h05:                             nxt = S_EX_BR;
               6'h02:                                    nxt = S_EX_J;
               6'h03:                                    nxt = S_EX_JAL;
               default:                                  nxt = S_IF;
            endcase
         end
         S_MEM_ADDR: nxt = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   nxt = MIO_ready ? S_WB_LW : S_MEM_RD;
         S_WB_LW:    nxt = S_IF;
         S_MEM_WR:   nxt = MIO_ready ? S_IF : S_MEM_WR;
         S_EX_R:     nxt = S_WB_R;
         S_WB_R:     nxt = S_IF;
         S_EX_BR:    nxt = S_IF;
         S_EX_J:     nxt = S_IF;
         S_EX_I:     nxt = S_WB_I;
         S_WB_I:     nxt = S_IF;
         S_EX_JAL:   nxt = S_IF;
         S_EX_JR:    nxt = S_IF;
         default:    nxt = S_IF;
      endcase
   end

   // bus outputs decoded from state
   always_comb begin
      mem_w    = (cur == S_MEM_WR);
      CPU_MIO  = (cur == S_IF) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
      Addr_out = (cur == S_IF) ? pc : alu_out;
   end

   // register-file write port selection
   always_comb begin
      rf_we = 1'b0;
      rf_wa = '0;
      rf_wd = '0;
      case (cur)
         S_WB_LW:  begin rf_we = 1'b1; rf_wa = rt;    rf_wd = mdr;     end
         S_WB_R:   begin rf_we = 1'b1; rf_wa = rd;    rf_wd = alu_out; end
         S_WB_I:   begin rf_we = 1'b1; rf_wa = rt;    rf_wd = alu_out; end
         S_EX_JAL: begin rf_we = 1'b1; rf_wa = 5'd31; rf_wd = pc;      end
         default:  ;
      endcase
   end

   // register file; $0 is never written
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) rf[i[4:0]] <= '0;
      end else if (rf_we && (rf_wa != 5'd0)) begin
         rf[rf_wa] <= rf_wd;
      end
   end

   // datapath registers updated per state
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc      <= '0;
         ir      <= '0;
         mdr     <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
      end else begin
         case (cur)
            S_IF: if (MIO_ready) begin
               ir <= Data_in;
               pc <= pc + 32'd4;
            end
            S_ID: begin
               a       <= rs_val;
               b       <= rt_val;
               alu_out <= pc + {imm_se[29:0], 2'b00};
            end
            S_MEM_ADDR: alu_out <= a + imm_se;
            S_MEM_RD:   if (MIO_ready) mdr <= Data_in;
            S_EX_R:     alu_out <= r_result;
            S_EX_BR:    if (br_taken) pc <= alu_out;
            S_EX_J:     pc <= jtarget;
            S_EX_I:     alu_out <= i_result;
            S_EX_JAL:   pc <= jtarget;
            S_EX_JR:    pc <= a;
            default:    ;
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu.sv
// tb_mcpu: directed cycle table, corner sequences and random programs vs an ISA-level model.
`timescale 1ns/1ps
module tb_mcpu;
   logic        clk = 1'b0;
   logic        reset, INT, MIO_ready;
   logic [31:0] Data_in;
   logic        mem_w, CPU_MIO;
   logic [31:0] PC_out, inst_out, Data_out, Addr_out;
   logic [4:0]  state;

   int checks = 0;
   int errors = 0;

   logic [31:0] dmem [1024];
   logic [31:0] mr [32];
   logic [31:0] mm [1024];
   logic [31:0] mpc;

   mcpu dut (
      .clk(clk), .reset(reset), .INT(INT), .MIO_ready(MIO_ready), .Data_in(Data_in),
      .mem_w(mem_w), .PC_out(PC_out), .inst_out(inst_out), .Data_out(Data_out),
      .Addr_out(Addr_out), .CPU_MIO(CPU_MIO), .state(state)
   );

   always #5 clk = ~clk;

   assign Data_in = dmem[Addr_out[11:2]];

   typedef struct {
      logic        rdy;
      logic [4:0]  st;
      logic [31:0] pc;
      logic [31:0] ir;
      logic        mw;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(logic rdy, logic [4:0] st, logic [31:0] pc, logic [31:0] ir, logic mw);
      vec_t v;
      v.rdy = rdy; v.st = st; v.pc = pc; v.ir = ir; v.mw = mw;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // advance one cycle (negedge to negedge); the bench memory commits a store on the accepting edge
   task automatic tick();
      logic        wr;
      logic [31:0] wa, wd;
      wr = reset && mem_w && MIO_ready;
      wa = Addr_out;
      wd = Data_out;
      @(negedge clk);
      if (wr) dmem[wa[11:2]] = wd;
      INT = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      MIO_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) dmem[i[9:0]] = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_pc"}, PC_out, 32'd0);
      chk({tag, "_ir"}, inst_out, 32'd0);
      chk({tag, "_addr"}, Addr_out, 32'd0);
      chk({tag, "_dout"}, Data_out, 32'd0);
      chk({tag, "_cpumio"}, 32'(CPU_MIO), 32'd1);
      chk({tag, "_memw"}, 32'(mem_w), 32'd0);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      int unsigned k;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom);
      imm = 16'($urandom);
      k   = $urandom_range(0, 24);
      case (k)
         0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
         1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
         2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
         5:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
         6:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         7:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
         8:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
         9:  return {6'h00, rs, 15'd0, 6'h08};
         10: return {6'h08, rs, rt, imm};
         11: return {6'h0C, rs, rt, imm};
         12: return {6'h0D, rs, rt, imm};
         13: return {6'h0E, rs, rt, imm};
         14: return {6'h0A, rs, rt, imm};
         15: return {6'h0F, rs, rt, imm};
         16, 17: return {6'h23, rs, rt, imm};
         18, 19, 20: return {6'h2B, rs, rt, imm};
         21: return {6'h04, rs, rt, 16'($urandom_range(0, 8))};
         22: return {6'h05, rs, rt, 16'($urandom_range(0, 8))};
         23: return {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom_range(0, 255))};
         default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      endcase
   endfunction

   // architectural step: executes one instruction on the model state
   task automatic model_step(output int cyc, output bit memop, output bit issw,
                             output logic [31:0] swa, output logic [31:0] swd, output logic [31:0] ins);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh, wi;
      logic [31:0] se, ze, va, vb, pc4, npc, wv, addr;
      bit          wr;
      ins = mm[mpc[11:2]];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0, ins[15:0]};
      va = mr[rs]; vb = mr[rt];
      pc4 = mpc + 32'd4; npc = pc4;
      wr = 0; wi = rt; wv = '0; cyc = 2; memop = 0; issw = 0; swa = '0; swd = '0;
      case (op)
         6'h00: begin
            wi = rd;
            case (fn)
               6'h20: begin wr = 1; wv = va + vb; cyc = 4; end
               6'h22: begin wr = 1; wv = va - vb; cyc = 4; end
               6'h24: begin wr = 1; wv = va & vb; cyc = 4; end
               6'h25: begin wr = 1; wv = va | vb; cyc = 4; end
               6'h26: begin wr = 1; wv = va ^ vb; cyc = 4; end
               6'h27: begin wr = 1; wv = ~(va | vb); cyc = 4; end
               6'h2A: begin wr = 1; wv = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0; cyc = 4; end
               6'h00: begin wr = 1; wv = vb << sh; cyc = 4; end
               6'h02: begin wr = 1; wv = vb >> sh; cyc = 4; end
               6'h08: begin npc = va; cyc = 3; end
               default: ;
            endcase
         end
         6'h08: begin wr = 1; wv = va + se; cyc = 4; end
         6'h0C: begin wr = 1; wv = va & ze; cyc = 4; end
         6'h0D: begin wr = 1; wv = va | ze; cyc = 4; end
         6'h0E: begin wr = 1; wv = va ^ ze; cyc = 4; end
         6'h0A: begin wr = 1; wv = ($signed(va) < $signed(se)) ? 32'd1 : 32'd0; cyc = 4; end
         6'h0F: begin wr = 1; wv = {ins[15:0], 16'h0}; cyc = 4; end
         6'h23: begin addr = va + se; wr = 1; wv = mm[addr[11:2]]; cyc = 5; memop = 1; end
         6'h2B: begin
            addr = va + se; mm[addr[11:2]] = vb; cyc = 4; memop = 1; issw = 1; swa = addr; swd = vb;
         end
         6'h04: begin if (va == vb) npc = pc4 + (se << 2); cyc = 3; end
         6'h05: begin if (va != vb) npc = pc4 + (se << 2); cyc = 3; end
         6'h02: begin npc = {pc4[31:28], ins[25:0], 2'b00}; cyc = 3; end
         6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wr = 1; wi = 5'd31; wv = pc4; cyc = 3; end
         default: ;
      endcase
      if (wr && wi != 5'd0) mr[wi] = wv;
      mpc = npc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          cyc, sif, smem, total, mwc;
      bit          memop, issw, rdy;
      logic [31:0] swa, swd, ins, oldpc;
      logic [31:0] i0, i1, i2, i3, i4;

      i0 = 32'h20080004; i1 = 32'h00084880; i2 = 32'h000940C2; i3 = 32'hAC080000; i4 = 32'h00000008;
      tbl[0]  = mk(0, 0,  32'h00, 32'h0, 0);
      tbl[1]  = mk(0, 0,  32'h00, 32'h0, 0);
      tbl[2]  = mk(0, 0,  32'h00, 32'h0, 0);
      tbl[3]  = mk(1, 0,  32'h00, 32'h0, 0);
      tbl[4]  = mk(1, 1,  32'h04, i0, 0);
      tbl[5]  = mk(1, 10, 32'h04, i0, 0);
      tbl[6]  = mk(1, 11, 32'h04, i0, 0);
      tbl[7]  = mk(1, 0,  32'h04, i0, 0);
      tbl[8]  = mk(1, 1,  32'h08, i1, 0);
      tbl[9]  = mk(1, 6,  32'h08, i1, 0);
      tbl[10] = mk(1, 7,  32'h08, i1, 0);
      tbl[11] = mk(1, 0,  32'h08, i1, 0);
      tbl[12] = mk(1, 1,  32'h0C, i2, 0);
      tbl[13] = mk(1, 6,  32'h0C, i2, 0);
      tbl[14] = mk(1, 7,  32'h0C, i2, 0);
      tbl[15] = mk(1, 0,  32'h0C, i2, 0);
      tbl[16] = mk(1, 1,  32'h10, i3, 0);
      tbl[17] = mk(1, 2,  32'h10, i3, 0);
      tbl[18] = mk(0, 5,  32'h10, i3, 1);
      tbl[19] = mk(1, 5,  32'h10, i3, 1);
      tbl[20] = mk(1, 0,  32'h10, i3, 0);
      tbl[21] = mk(1, 1,  32'h14, i4, 0);
      tbl[22] = mk(1, 13, 32'h14, i4, 0);
      tbl[23] = mk(1, 0,  32'h00, i4, 0);

      INT = 1'b0; reset = 1'b0; MIO_ready = 1'b1;
      clear_mem();
      @(negedge clk);
      do_reset();
      chk_reset_outputs("reset");

      // directed program with an IF stall and a stalled store
      dmem[0] = i0; dmem[1] = i1; dmem[2] = i2; dmem[3] = i3; dmem[4] = i4;
      for (int r = 0; r < 24; r++) begin
         chk($sformatf("tbl%0d_state", r), 32'(state), 32'(tbl[r].st));
         chk($sformatf("tbl%0d_pc", r), PC_out, tbl[r].pc);
         chk($sformatf("tbl%0d_ir", r), inst_out, tbl[r].ir);
         chk($sformatf("tbl%0d_memw", r), 32'(mem_w), 32'(tbl[r].mw));
         if (tbl[r].st == 5'd0) chk($sformatf("tbl%0d_addr_if", r), Addr_out, tbl[r].pc);
         if (tbl[r].mw) begin
            chk($sformatf("tbl%0d_sw_addr", r), Addr_out, 32'h0);
            chk($sformatf("tbl%0d_sw_data", r), Data_out, 32'h2);
         end
         MIO_ready = tbl[r].rdy;
         tick();
      end
      chk("tbl_store_mem", dmem[0], 32'h2);

      // jal then sw $31 shows the link value
      clear_mem();
      dmem[0] = 32'h0C000004; dmem[4] = 32'hAC1F0000;
      do_reset();
      repeat (3) tick();
      chk("jal_pc", PC_out, 32'h10);
      chk("jal_state", 32'(state), 32'd0);
      repeat (3) tick();
      chk("jal_sw_state", 32'(state), 32'd5);
      chk("jal_sw_memw", 32'(mem_w), 32'd1);
      chk("jal_sw_data", Data_out, 32'h4);
      tick();
      chk("jal_sw_mem", dmem[0], 32'h4);

      // beq taken back to itself, bne not taken
      clear_mem();
      dmem[0] = 32'h1000FFFF;
      do_reset();
      tick();
      chk("beq_pc_after_if", PC_out, 32'h4);
      repeat (2) tick();
      chk("beq_pc", PC_out, 32'h0);
      chk("beq_state", 32'(state), 32'd0);
      dmem[0] = 32'h1400FFFF;
      do_reset();
      repeat (3) tick();
      chk("bne_pc", PC_out, 32'h4);
      chk("bne_state", 32'(state), 32'd0);

      // reset landing on a write-back edge must suppress it
      clear_mem();
      dmem[0] = 32'h20080005;
      do_reset();
      repeat (3) tick();
      chk("midrst_state_wbi", 32'(state), 32'd11);
      dmem[0] = 32'hAC080000;
      do_reset();
      chk_reset_outputs("midrst");
      repeat (3) tick();
      chk("midrst_sw_state", 32'(state), 32'd5);
      chk("midrst_sw_data", Data_out, 32'h0);

      // random programs against the ISA model with random bus stalls
      for (int i = 0; i < 1024; i++) begin
         dmem[i[9:0]] = (i < 256) ? rnd_instr() : $urandom;
         mm[i[9:0]] = dmem[i[9:0]];
      end
      for (int i = 0; i < 32; i++) mr[i[4:0]] = '0;
      mpc = '0;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         chk("rnd_state_if", 32'(state), 32'd0);
         chk("rnd_pc", PC_out, mpc);
         oldpc = mpc;
         model_step(cyc, memop, issw, swa, swd, ins);
         sif   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         smem  = (memop && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         total = cyc + sif + smem;
         mwc   = 0;
         for (int c = 0; c < total; c++) begin
            rdy = !((c < sif) || (memop && c >= sif + 3 && c < sif + 3 + smem));
            MIO_ready = rdy;
            if (c > 0 && c <= sif) begin
               chk("rnd_stall_pc", PC_out, oldpc);
               chk("rnd_stall_state", 32'(state), 32'd0);
            end
            if (c == sif + 1) chk("rnd_ir", inst_out, ins);
            if (mem_w) begin
               mwc++;
               if (issw) begin
                  chk("rnd_sw_addr", Addr_out, swa);
                  chk("rnd_sw_data", Data_out, swd);
               end
            end
            tick();
         end
         chk("rnd_memw_cycles", 32'(mwc), issw ? 32'(smem + 1) : 32'd0);
      end
      MIO_ready = 1'b1;
      do_reset();
      chk_reset_outputs("final_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
